// File: rtl/lm07_spi_reader.sv
// -----------------------------------------------------------------------------
// lm07_spi_reader
//
// Reads 16-bit frames from an LM07-style SPI temperature sensor. A read starts
// from IDLE on `start`, or by itself when automatic sampling is compiled in.
// The block drops cs, waits CLK_DIV cycles, then generates 16 SCK periods
// (CLK_DIV cycles high, CLK_DIV cycles low). sio is shifted into the LSB of a
// shift register on every clk edge that raises sck. When the 16th low phase
// ends, cs rises, the frame is published on data/temp_c with a one-cycle valid
// pulse, and the block holds cs high for 2*CLK_DIV cycles before it returns to
// IDLE.
//
// Parameters
//   CLK_DIV   clk cycles per SCK half-period (1..255)
//   AUTO_GAP  idle clk cycles before an automatic read (auto-sample builds only)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous reset, active-low
//   start   in   read request, sampled only in IDLE
//   sio     in   serial data from the sensor
//   cs      out  sensor chip select, active-low
//   sck     out  serial clock to the sensor
//   busy    out  high in every state except IDLE
//   data    out  last complete frame, MSB first as received
//   temp_c  out  signed integer degrees C, data[15:7]
//   valid   out  one-cycle pulse when data/temp_c update
//
// Build option
//   LM07_AUTO_SAMPLE_EN  when defined, a read is started automatically
//                        AUTO_GAP+1 cycles after IDLE is entered (including
//                        after reset); start is still honoured in IDLE.
// -----------------------------------------------------------------------------
module lm07_spi_reader #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned AUTO_GAP = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sio,
   output logic        cs,
   output logic        sck,
   output logic        busy,
   output logic [15:0] data,
   output logic [8:0]  temp_c,
   output logic        valid
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_HI,
      SCK_LO,
      GAP
   } state_t;

   // Divider is wide enough for the GAP phase, which lasts 2*CLK_DIV cycles.
   localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

   state_t      state;
   logic [8:0]  div_cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] shreg;
   logic        div_done;
   logic        auto_go;
   logic        go;

   assign div_done = (div_cnt == DIV_LAST);
   assign go       = start | auto_go;

`ifdef LM07_AUTO_SAMPLE_EN
   logic [31:0] idle_cnt;

   // Counts cycles spent in IDLE; cleared in every other state so each entry
   // into IDLE (and reset) restarts the automatic-read interval.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (state != IDLE) begin
         idle_cnt <= '0;
      end else if (idle_cnt != 32'(AUTO_GAP)) begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end

   assign auto_go = (state == IDLE) && (idle_cnt == 32'(AUTO_GAP));
`else
   // Automatic sampling is not built; the term is constant-false and only
   // keeps AUTO_GAP referenced so the parameter list stays identical.
   assign auto_go = 1'b0 && (AUTO_GAP != 0);
`endif

   // Single state machine; every output is registered and changes on the same
   // edge as the state it belongs to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cs      <= 1'b1;
         sck     <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         data    <= '0;
         temp_c  <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               cs      <= 1'b1;
               sck     <= 1'b0;
               div_cnt <= '0;
               bit_cnt <= '0;
               if (go) begin
                  state <= SETUP;
                  cs    <= 1'b0;
                  busy  <= 1'b1;
                  shreg <= '0;
               end
            end

            SETUP: begin
               if (div_done) begin
                  state   <= SCK_HI;
                  sck     <= 1'b1;
                  shreg   <= {shreg[14:0], sio};
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            SCK_HI: begin
               if (div_done) begin
                  state   <= SCK_LO;
                  sck     <= 1'b0;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            SCK_LO: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (bit_cnt == 4'd15) begin
                     // Frame complete: release the sensor and publish.
                     state   <= GAP;
                     cs      <= 1'b1;
                     bit_cnt <= '0;
                     data    <= shreg;
                     temp_c  <= shreg[15:7];
                     valid   <= 1'b1;
                  end else begin
                     state   <= SCK_HI;
                     sck     <= 1'b1;
                     shreg   <= {shreg[14:0], sio};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            GAP: begin
               if (div_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            default: begin
               state   <= IDLE;
               cs      <= 1'b1;
               sck     <= 1'b0;
               busy    <= 1'b0;
               div_cnt <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule
